// File: rtl/wb_write_port_pkg.sv
// wb_write_port_pkg: shared widths and constants for the regfile write port
package wb_write_port_pkg;
  localparam int REG_BUS = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int WB_FIFO_DEPTH = 4;
  localparam int WB_FIFO_DEPTH_LOG2 = 2;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
endpackage

// File: rtl/wb_write_port_fifo.sv
// wb_fifo: result buffer holding {addr,data} entries in acceptance order
import wb_write_port_pkg::*;
module wb_fifo #(
  parameter int W = REG_BUS + REG_ADDR_BUS,
  parameter int DEPTH = WB_FIFO_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [PW:0]  count
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign dout = mem[rd_ptr];
  // storage array, written at the tail on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  // pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/wb_write_port.sv
// wb_write_port: arbitrates A/B results into a buffer, drains one regfile write per cycle, tracks pending writes (WB_BYPASS_EN adds same-cycle bypass)
import wb_write_port_pkg::*;
module wb_write_port #(
  parameter int DATA_W = REG_BUS,
  parameter int ADDR_W = REG_ADDR_BUS,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  input  logic                 sb_set,
  input  logic [ADDR_W-1:0]    sb_addr,
  output logic [2**ADDR_W-1:0] pending,
  output logic                 we,
  output logic [ADDR_W-1:0]    waddr,
  output logic [DATA_W-1:0]    wdata
);
  localparam int NREG = 2**ADDR_W;
  localparam int CW = $clog2(FIFO_DEPTH);
`ifdef WB_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif
  logic full, empty, take, keep, byp, push, pop, r_we;
  logic [CW:0] count;
  logic [ADDR_W-1:0] src_addr, h_addr, r_waddr;
  logic [DATA_W-1:0] src_data, h_data, r_wdata;
  logic [NREG-1:0] clr_mask, set_mask;
  assign a_ready = !full;
  assign b_ready = !full & !a_valid;
  assign take = (a_valid | b_valid) & !full;
  assign src_addr = a_valid ? a_addr : b_addr;
  assign src_data = a_valid ? a_data : b_data;
  assign keep = take & (src_addr != '0);
  assign byp = BYPASS & keep & empty;
  assign push = keep & !byp;
  assign pop = count != '0;
  wb_fifo #(.W(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din({src_addr, src_data}), .pop(pop),
    .dout({h_addr, h_data}), .full(full), .empty(empty), .count(count)
  );
  // registered drain path: head leaves the buffer into the write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= pop;
      if (pop) {r_waddr, r_wdata} <= {h_addr, h_data};
    end
  end
  assign we = r_we | byp;
  assign waddr = byp ? src_addr : r_waddr;
  assign wdata = byp ? src_data : r_wdata;
  assign clr_mask = pop ? NREG'(1) << h_addr : byp ? NREG'(1) << src_addr : '0;
  assign set_mask = (sb_set && sb_addr != '0) ? NREG'(1) << sb_addr : '0;
  // scoreboard: clear on the write edge, set from ID wins, x0 never pending
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else pending <= ((pending & ~clr_mask) | set_mask) & ~NREG'(1);
  end
endmodule
